// File: rtl/adj_repeat_gen.sv
// adj_repeat_gen: time-adjust pulse generator with auto-repeat.
//
// Classifies each ADJ press as a glitch, a short press or a long hold:
//   - glitch (shorter than DEB_MIN samples): ignored
//   - short press: one PULSE_W-wide pulse on the latched channel at release
//   - long hold (LONG_HOLD samples): a pulse on entry to auto-repeat, then one
//     every REP_PERIOD cycles until release
//
// Parameters:
//   NCH        number of adjust channels (bit 0 = seconds, bit 1 = minutes, ...)
//   SEL_W      width of adj_sel
//   DEB_MIN    minimum consecutive high samples for a valid short press
//   LONG_HOLD  consecutive high samples that enter auto-repeat (> DEB_MIN)
//   REP_PERIOD cycles between auto-repeat pulses (> PULSE_W)
//   PULSE_W    adjust pulse width in cycles
//   CNT_W      hold/repeat counter width (2**CNT_W > LONG_HOLD)
//
// Ports:
//   clk_adj        adjust clock, rising edge
//   reset          synchronous reset, active-low
//   adj            button level, 1 = pressed
//   adj_sel        channel select: 0 = off, 1..NCH = channel+1, >NCH = off
//   adj_pulse      one-hot adjust pulse to the counters (registered)
//   led            mirror of adj_pulse
//   busy           FSM not idle
//   repeat_active  FSM in auto-repeat
module adj_repeat_gen #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned SEL_W      = $clog2(NCH + 1),
  parameter int unsigned DEB_MIN    = 4,
  parameter int unsigned LONG_HOLD  = 30,
  parameter int unsigned REP_PERIOD = 8,
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_adj,
  input  logic             reset,
  input  logic             adj,
  input  logic [SEL_W-1:0] adj_sel,
  output logic [NCH-1:0]   adj_pulse,
  output logic [NCH-1:0]   led,
  output logic             busy,
  output logic             repeat_active
);

  localparam int unsigned PwW = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [SEL_W-1:0]   pulse_ch_q, pulse_ch_d;
  logic [PwW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [NCH-1:0]     adj_pulse_q, adj_pulse_d;
  logic               busy_q, busy_d;
  logic               rep_act_q, rep_act_d;

  logic               sel_ok;
  logic               fire;
  logic [CNT_W-1:0]   hold_inc;

  assign sel_ok   = (adj_sel != '0) && (adj_sel <= SEL_W'(NCH));
  assign hold_inc = hold_q + CNT_W'(1);

  // Press classification and auto-repeat timing.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    ch_d    = ch_q;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (adj && sel_ok) begin
          state_d = StHold;
          ch_d    = adj_sel - SEL_W'(1);
          hold_d  = CNT_W'(1);
        end
      end
      StHold: begin
        if (!sel_ok) begin
          // Deselect aborts the press before any release/threshold decision.
          state_d = StIdle;
          hold_d  = '0;
        end else if (!adj) begin
          // Release is evaluated before the threshold, so it always wins.
          fire    = (hold_q >= CNT_W'(DEB_MIN));
          state_d = StIdle;
          hold_d  = '0;
        end else begin
          hold_d = hold_inc;
          if (hold_inc == CNT_W'(LONG_HOLD)) begin
            state_d = StRepeat;
            fire    = 1'b1;
            rep_d   = '0;
          end
        end
      end
      StRepeat: begin
        if (!adj || !sel_ok) begin
          state_d = StIdle;
          hold_d  = '0;
          rep_d   = '0;
        end else if (rep_q == CNT_W'(REP_PERIOD - 1)) begin
          fire  = 1'b1;
          rep_d = '0;
        end else begin
          rep_d = rep_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  // Pulse stretcher; a pulse in flight finishes regardless of FSM state.
  always_comb begin
    pulse_ch_d  = pulse_ch_q;
    pulse_cnt_d = pulse_cnt_q;
    if (fire) begin
      pulse_ch_d  = ch_q;
      pulse_cnt_d = PwW'(PULSE_W);
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - PwW'(1);
    end
    adj_pulse_d = (pulse_cnt_d != '0) ? (NCH'(1) << pulse_ch_d) : '0;
    busy_d      = (state_d != StIdle);
    rep_act_d   = (state_d == StRepeat);
  end

  always_ff @(posedge clk_adj) begin
    if (!reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      rep_q       <= '0;
      ch_q        <= '0;
      pulse_ch_q  <= '0;
      pulse_cnt_q <= '0;
      adj_pulse_q <= '0;
      busy_q      <= 1'b0;
      rep_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      ch_q        <= ch_d;
      pulse_ch_q  <= pulse_ch_d;
      pulse_cnt_q <= pulse_cnt_d;
      adj_pulse_q <= adj_pulse_d;
      busy_q      <= busy_d;
      rep_act_q   <= rep_act_d;
    end
  end

  assign adj_pulse     = adj_pulse_q;
  assign led           = adj_pulse_q;
  assign busy          = busy_q;
  assign repeat_active = rep_act_q;

endmodule

// File: tb/tb_adj_repeat_gen.sv
// Scoreboard bench for adj_repeat_gen: a 2-channel and a 4-channel instance.
// Stimulus pushes expected (edge number, pulse value) pairs; a monitor pops
// one entry per cycle in which a DUT drives a non-zero pulse.
module tb_adj_repeat_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       adj;
  logic [1:0] sel2;
  logic [2:0] sel4;
  logic [1:0] pulse2, led2;
  logic [3:0] pulse4, led4;
  logic       busy2, rep2, busy4, rep4;

  always #5 clk = ~clk;

  adj_repeat_gen dut2 (
    .clk_adj       (clk),
    .reset         (rst_n),
    .adj           (adj),
    .adj_sel       (sel2),
    .adj_pulse     (pulse2),
    .led           (led2),
    .busy          (busy2),
    .repeat_active (rep2)
  );

  adj_repeat_gen #(.NCH(4)) dut4 (
    .clk_adj       (clk),
    .reset         (rst_n),
    .adj           (adj),
    .adj_sel       (sel4),
    .adj_pulse     (pulse4),
    .led           (led4),
    .busy          (busy4),
    .repeat_active (rep4)
  );

  int cyc = 0;  // number of rising edges seen
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int         q2_cyc[$];
  logic [1:0] q2_val[$];
  int         q4_cyc[$];
  logic [3:0] q4_val[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse on dut2 visible after edges e .. e+n-1.
  task automatic push2(input int e, input logic [1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      q2_cyc.push_back(e + k);
      q2_val.push_back(v);
    end
  endtask

  task automatic push4(input int e, input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      q4_cyc.push_back(e + k);
      q4_val.push_back(v);
    end
  endtask

  // Monitor: compares each observed pulse cycle against the scoreboard.
  always @(negedge clk) begin
    if (pulse2 != 2'b00) begin
      if (q2_cyc.size() == 0) begin
        check("unexpected_pulse2", {30'd0, pulse2}, 32'd0);
      end else begin
        int         ec;
        logic [1:0] ev;
        ec = q2_cyc.pop_front();
        ev = q2_val.pop_front();
        check("pulse2_edge", cyc, ec);
        check("pulse2_val", {30'd0, pulse2}, {30'd0, ev});
        check("led2", {30'd0, led2}, {30'd0, ev});
      end
    end else if (led2 != 2'b00) begin
      check("led2_idle", {30'd0, led2}, 32'd0);
    end
    if (pulse4 != 4'b0000) begin
      if (q4_cyc.size() == 0) begin
        check("unexpected_pulse4", {28'd0, pulse4}, 32'd0);
      end else begin
        int         ec;
        logic [3:0] ev;
        ec = q4_cyc.pop_front();
        ev = q4_val.pop_front();
        check("pulse4_edge", cyc, ec);
        check("pulse4_val", {28'd0, pulse4}, {28'd0, ev});
        check("led4", {28'd0, led4}, {28'd0, ev});
      end
    end else if (led4 != 4'b0000) begin
      check("led4_idle", {28'd0, led4}, 32'd0);
    end
  end

  initial begin
    int e;
    rst_n = 1'b0;
    adj   = 1'b0;
    sel2  = 2'd0;
    sel4  = 3'd0;
    tick(3);
    check("rst_pulse2", {30'd0, pulse2}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_rep2", {31'd0, rep2}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: short press, 6 high samples on channel 0.
    sel2 = 2'd1;
    adj  = 1'b1;
    tick(6);
    check("t1_busy_held", {31'd0, busy2}, 32'd1);
    adj = 1'b0;
    push2(cyc + 1, 2'b01, 4);
    tick(1);
    check("t1_busy_fall", {31'd0, busy2}, 32'd0);
    tick(8);

    // 2: glitch, 3 high samples on channel 1.
    sel2 = 2'd2;
    adj  = 1'b1;
    tick(1);
    check("t2_busy_rise", {31'd0, busy2}, 32'd1);
    tick(2);
    check("t2_busy_held", {31'd0, busy2}, 32'd1);
    adj = 1'b0;
    tick(1);
    check("t2_busy_fall", {31'd0, busy2}, 32'd0);
    tick(8);

    // 3: long hold, 46 high samples on channel 1.
    sel2 = 2'd2;
    adj  = 1'b1;
    e    = cyc + 1;
    push2(e + 29, 2'b10, 4);
    push2(e + 37, 2'b10, 4);
    push2(e + 45, 2'b10, 4);
    tick(29);
    check("t3_rep_before", {31'd0, rep2}, 32'd0);
    tick(1);
    check("t3_rep_rise", {31'd0, rep2}, 32'd1);
    tick(16);
    check("t3_rep_held", {31'd0, rep2}, 32'd1);
    adj = 1'b0;
    tick(1);
    check("t3_rep_fall", {31'd0, rep2}, 32'd0);
    check("t3_busy_fall", {31'd0, busy2}, 32'd0);
    tick(8);

    // 4a: select changes to another valid channel mid-press; latched ch wins.
    sel2 = 2'd1;
    adj  = 1'b1;
    tick(5);
    sel2 = 2'd2;
    tick(5);
    adj = 1'b0;
    push2(cyc + 1, 2'b01, 4);
    tick(8);

    // 4b: select goes to 0 mid-press: abort, no pulse.
    sel2 = 2'd1;
    adj  = 1'b1;
    tick(5);
    sel2 = 2'd0;
    tick(1);
    check("t4_abort_busy", {31'd0, busy2}, 32'd0);
    adj = 1'b0;
    tick(8);

    // 5: reset while in REPEAT with a pulse in flight.
    sel2 = 2'd2;
    adj  = 1'b1;
    e    = cyc + 1;
    push2(e + 29, 2'b10, 2);  // cut short by reset at edge e+31
    tick(31);
    check("t5_rep_before_rst", {31'd0, rep2}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("t5_rst_pulse", {30'd0, pulse2}, 32'd0);
    check("t5_rst_led", {30'd0, led2}, 32'd0);
    check("t5_rst_busy", {31'd0, busy2}, 32'd0);
    check("t5_rst_rep", {31'd0, rep2}, 32'd0);
    rst_n = 1'b1;
    e     = cyc + 1;
    tick(1);
    check("t5_busy_restart", {31'd0, busy2}, 32'd1);
    // Hold count restarted at 1: repeat starts exactly 30 samples in.
    tick(28);
    check("t5_rep_not_yet", {31'd0, rep2}, 32'd0);
    push2(e + 29, 2'b10, 4);
    tick(1);
    check("t5_rep_rise", {31'd0, rep2}, 32'd1);
    adj = 1'b0;
    tick(1);
    check("t5_busy_fall", {31'd0, busy2}, 32'd0);
    tick(8);

    // 6a: out-of-range select on the 2-channel instance.
    sel2 = 2'd3;
    adj  = 1'b1;
    tick(1);
    check("t6_busy_start", {31'd0, busy2}, 32'd0);
    tick(39);
    check("t6_busy_end", {31'd0, busy2}, 32'd0);
    check("t6_rep_end", {31'd0, rep2}, 32'd0);
    adj = 1'b0;
    tick(4);

    // 6b: long hold on channel 3 of the 4-channel instance.
    sel2 = 2'd0;
    sel4 = 3'd4;
    adj  = 1'b1;
    e    = cyc + 1;
    push4(e + 29, 4'b1000, 4);
    push4(e + 37, 4'b1000, 4);
    push4(e + 45, 4'b1000, 4);
    tick(30);
    check("t6b_rep4_rise", {31'd0, rep4}, 32'd1);
    check("t6b_busy2_idle", {31'd0, busy2}, 32'd0);
    tick(16);
    adj = 1'b0;
    tick(1);
    check("t6b_rep4_fall", {31'd0, rep4}, 32'd0);
    tick(10);

    check("q2_drained", q2_cyc.size(), 32'd0);
    check("q4_drained", q4_cyc.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
